// File: rtl/dcount_ctl.sv
// Pacing/reload controller for a 16-bit loadable up-counter: prescaler, terminal compare, irq latch.
// Optional capture port set enabled by defining DCOUNT_CTL_CAPTURE_EN.
module dcount_ctl #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         resetl,
   input  logic [W-1:0] din,
   input  logic         pre_wr,
   input  logic         per_wr,
   input  logic         ctl_wr,
   input  logic         start,
   input  logic         stop,
   input  logic         irq_ack,
   input  logic [W-1:0] count,
   output logic         cnt_load,
   output logic         cnt_ena,
   output logic [W-1:0] cnt_data,
   output logic         running,
   output logic         tick,
`ifdef DCOUNT_CTL_CAPTURE_EN
   output logic         irq,
   input  logic         cap_in,
   output logic [W-1:0] cap_val
`else
   output logic         irq
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [W-1:0]   r_pre;
   logic [W-1:0]   r_per;
   logic           r_mode;
   logic [W-1:0]   r_pre_cnt;
   logic           r_cnt_load;
   logic           r_cnt_ena;
   logic           r_tick;
   logic           r_running;
   logic           r_irq;

   logic [W-1:0]   w_pre_nxt;
   logic [W-1:0]   w_cnt_nxt;
   logic [W-1:0]   w_per_nxt;
   logic           w_mode_nxt;
   logic           w_expire;
   logic           w_exp_nxt;
   logic           w_term_nxt;

   // Next state and prescaler; stop beats start, start restarts from any state.
   always_comb begin
      w_state_nxt = r_state;
      w_pre_nxt   = r_pre_cnt;
      w_expire    = (r_state == S_RUN) && (r_pre_cnt == '0);
      if (stop) begin
         w_state_nxt = S_IDLE;
      end else if (start) begin
         w_state_nxt = S_LOAD;
      end else begin
         case (r_state)
            S_LOAD: begin
               w_state_nxt = S_RUN;
               w_pre_nxt   = r_pre;
            end
            S_RUN: begin
               if (w_expire) begin
                  w_pre_nxt = r_pre;
                  if (r_tick && r_mode) w_state_nxt = S_DONE;
               end else begin
                  w_pre_nxt = r_pre_cnt - W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are registered, so decode them from the values the next cycle will see,
   // including the count the counter will hold once the current strobe lands.
   always_comb begin
      w_cnt_nxt  = r_cnt_load ? '0 : (r_cnt_ena ? count + W'(1) : count);
      w_per_nxt  = per_wr ? din : r_per;
      w_mode_nxt = ctl_wr ? din[0] : r_mode;
      w_exp_nxt  = (w_state_nxt == S_RUN) && (w_pre_nxt == '0);
      w_term_nxt = w_exp_nxt && (w_cnt_nxt == w_per_nxt);
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         r_state    <= S_IDLE;
         r_pre      <= '0;
         r_per      <= '0;
         r_mode     <= 1'b0;
         r_pre_cnt  <= '0;
         r_cnt_load <= 1'b0;
         r_cnt_ena  <= 1'b0;
         r_tick     <= 1'b0;
         r_running  <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pre_cnt  <= w_pre_nxt;
         if (pre_wr) r_pre <= din;
         if (per_wr) r_per <= din;
         if (ctl_wr) r_mode <= din[0];
         r_cnt_load <= (w_state_nxt == S_LOAD) || (w_term_nxt && !w_mode_nxt);
         r_cnt_ena  <= w_exp_nxt && !w_term_nxt;
         r_tick     <= w_term_nxt;
         r_running  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
         // Terminal set has priority over acknowledge.
         r_irq      <= r_tick | (r_irq & ~irq_ack);
      end
   end

   assign cnt_load = r_cnt_load;
   assign cnt_ena  = r_cnt_ena;
   assign cnt_data = '0;
   assign running  = r_running;
   assign tick     = r_tick;
   assign irq      = r_irq;

`ifdef DCOUNT_CTL_CAPTURE_EN
   logic         r_cap_s1;
   logic         r_cap_s2;
   logic         r_cap_d;
   logic [W-1:0] r_cap_val;

   // Two-flop synchroniser, rising-edge detect, then snapshot of count.
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         r_cap_s1  <= 1'b0;
         r_cap_s2  <= 1'b0;
         r_cap_d   <= 1'b0;
         r_cap_val <= '0;
      end else begin
         r_cap_s1 <= cap_in;
         r_cap_s2 <= r_cap_s1;
         r_cap_d  <= r_cap_s2;
         if (r_cap_s2 && !r_cap_d) r_cap_val <= count;
      end
   end

   assign cap_val = r_cap_val;
`endif

endmodule

// File: doc/dcount_ctl.md
Name: dcount_ctl

Overview:
- Control stage directly upstream of the 16-bit loadable up-counter. Drives the counter's load, ena and data inputs, and reads its count output back.
- Provides a programmable prescaler, a terminal-count compare, periodic or one-shot operation, and a latched interrupt with acknowledge.
- Used wherever a TOM timer or sequencer needs a counter that is paced and auto-reloaded.

Parameters:
- W, 16, width of counter, prescaler and period registers; bit 0 is the LSB.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- resetl  in  1  asynchronous, active-low reset.
- din  in  W  register write data.
- pre_wr  in  1  write din to pre_reg (prescale divisor minus 1).
- per_wr  in  1  write din to per_reg (terminal count value).
- ctl_wr  in  1  write din[0] to mode: 0 = periodic, 1 = one-shot.
- start  in  1  start or restart the sequence.
- stop  in  1  halt the sequence.
- irq_ack  in  1  clear the irq latch.
- count  in  W  current counter value, fed back from the counter.
- cnt_load  out  1  counter load strobe.
- cnt_ena  out  1  counter increment strobe.
- cnt_data  out  W  counter load value; always 0.
- running  out  1  high in LOAD and RUN.
- tick  out  1  one-cycle pulse on each terminal event.
- irq  out  1  latched interrupt.

Behaviour:
- Reset: all outputs 0; pre_reg, per_reg and mode are 0; prescale counter pre_cnt is 0; state is IDLE.
- Register writes take effect the next cycle. A new pre_reg value is used at the next prescale reload, not immediately. per_reg is compared live.
- States: IDLE, LOAD, RUN, DONE.
  - IDLE: all strobes low. start moves to LOAD.
  - LOAD (one cycle): cnt_load=1, cnt_data=0, pre_cnt<=pre_reg, then move to RUN.
  - RUN: pre_cnt decrements each cycle. When pre_cnt==0 it reloads from pre_reg and an "expire" occurs that cycle.
    - Expire with count!=per_reg: cnt_ena=1 for that cycle.
    - Expire with count==per_reg (terminal): tick=1 and irq<=1. In periodic mode, cnt_load=1 with data 0 and stay in RUN. In one-shot mode, no strobe and move to DONE.
  - DONE: strobes low, count holds. start moves to LOAD.
- Strobe rules: cnt_load and cnt_ena are never high in the same cycle. Each is asserted for exactly one cycle per event.
- Timing: the counter value updates one cycle after a strobe, so the terminal compare always uses the registered count.
- Periodic period: (per_reg+1)*(pre_reg+1) clocks between ticks. per_reg=0 gives a tick on every expire.
- stop in any state moves to IDLE next cycle with strobes low. If stop and start are asserted together, stop wins.
- start while in RUN restarts: moves to LOAD.
- irq: set by terminal, cleared by irq_ack. If set and clear occur in the same cycle, set wins. stop does not clear irq.
- Asynchronous reset mid-sequence forces IDLE immediately. The counter itself is not reset by this block.
- Arithmetic: pre_cnt is W-bit unsigned. The compare is a full W-bit equality check.

Optional Feature:
- Macro DCOUNT_CTL_CAPTURE_EN.
- With the macro defined, two extra ports are added:
  - cap_in, in, 1: capture request.
  - cap_val, out, W: captured counter value.
- Capture operation:
  - cap_in is synchronised through a 2-flop stage, then rising-edge detected.
  - On the detected edge, count is registered into cap_val. Total latency from the cap_in edge to cap_val updating is 3 cycles.
  - cap_val resets to 0.
  - A capture on the same cycle as a terminal event captures per_reg's value as present on count.
- Without the macro: no extra ports and no capture logic.

Test Plan:
- Reset, then pre_reg=0, per_reg=3, periodic, start: cnt_load in cycle 1, then cnt_ena for 3 cycles, then tick+cnt_load. tick repeats every 4 clocks and irq=1 after the first tick.
- pre_reg=2, per_reg=1, one-shot, start: cnt_ena pulses every 3 clocks. One tick when count==1, then DONE, running=0, count holds at 1.
- irq_ack asserted in the same cycle as tick: irq stays 1. irq_ack alone on the next cycle: irq=0.
- start and stop together while in RUN: IDLE next cycle, no cnt_load. Then start alone: LOAD with cnt_data=0.
- Write pre_reg=5 during RUN with pre_reg previously 1: the current prescale window completes at 2 clocks, and the following window is 6 clocks.
- With DCOUNT_CTL_CAPTURE_EN defined, pulse cap_in when count==0x0007: cap_val=0x0007 three cycles later. Assert resetl low mid-run: all outputs 0 asynchronously.
